// File: rtl/mlsib_key_injector_if.sv
// rtl/mlsib_key_injector_if.sv - host key port and scan-segment pins of the lock-SIB key injector
interface mlsib_key_injector_if #(
    parameter int Length = 256,
    parameter int TriesW = 2
);
    logic [Length-1:0] KeyIn;
    logic              KeyLoad;
    logic              SibOpen;
    logic              SI;
    logic              ShiftEN;
    logic              CaptureEN;
    logic              UpdateEn;
    logic              Select;
    logic              Busy;
    logic              Done;
    logic              Pass;
    logic              LockedOut;
    logic [TriesW-1:0] Tries;

    modport master (
        input  KeyIn, KeyLoad, SibOpen,
        output SI, ShiftEN, CaptureEN, UpdateEn, Select, Busy, Done, Pass, LockedOut, Tries
    );

    modport slave (
        output KeyIn, KeyLoad, SibOpen,
        input  SI, ShiftEN, CaptureEN, UpdateEn, Select, Busy, Done, Pass, LockedOut, Tries
    );
endinterface

// File: rtl/mlsib_key_injector.sv
// rtl/mlsib_key_injector.sv - serialises a host key into the locking SIB chain and checks it opened
module mlsib_key_injector #(
    parameter int Length    = 256,
    parameter int PadBits   = 1,
    parameter int MaxTries  = 3,
    parameter int SettleCyc = 2
) (
    input logic                  Clock,
    input logic                  Rst,
    mlsib_key_injector_if.master bus
);
    localparam int ShiftCyc = Length + PadBits;
    localparam int CntW     = $clog2(ShiftCyc + SettleCyc + 1);
    localparam int TriesW   = $clog2(MaxTries + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_UPDATE, S_SETTLE, S_CHECK, S_LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Length-1:0] shadow_q, shadow_d;
    logic [TriesW-1:0] tries_q, tries_d;
    logic              locked_q, locked_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              si_q, si_d;
    logic              shift_en_q, shift_en_d;
    logic              update_en_q, update_en_d;
    logic              select_q, select_d;
    logic              busy_q, busy_d;

    // Outputs are registered images of the next state, so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        tries_d  = tries_q;
        locked_d = locked_q;
        pass_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.KeyLoad && !locked_q) begin
                    state_d  = S_SHIFT;
                    shadow_d = bus.KeyIn;
                    cnt_d    = '0;
                end
            end
            S_SHIFT: begin
                shadow_d = shadow_q >> 1;
                if (cnt_q == CntW'(ShiftCyc - 1)) begin
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                // SibOpen is sampled on the edge that enters CHECK, so Done and Pass appear together.
                if (cnt_q == CntW'(SettleCyc - 1)) begin
                    state_d  = S_CHECK;
                    done_d   = 1'b1;
                    shadow_d = '0;
                    if (bus.SibOpen) begin
                        pass_d  = 1'b1;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_d == TriesW'(MaxTries)) begin
                            locked_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                shadow_d = '0;
                state_d  = locked_q ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                shadow_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        shift_en_d  = (state_d == S_SHIFT);
        update_en_d = (state_d == S_UPDATE);
        select_d    = (state_d == S_SHIFT) || (state_d == S_UPDATE) || (state_d == S_SETTLE);
        busy_d      = select_d;
        si_d        = 1'b0;
        if (state_d == S_SHIFT) begin
            si_d = (cnt_d < CntW'(Length)) ? shadow_d[0] : 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            tries_q     <= '0;
            locked_q    <= 1'b0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            si_q        <= 1'b0;
            shift_en_q  <= 1'b0;
            update_en_q <= 1'b0;
            select_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            tries_q     <= tries_d;
            locked_q    <= locked_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            si_q        <= si_d;
            shift_en_q  <= shift_en_d;
            update_en_q <= update_en_d;
            select_q    <= select_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.SI        = si_q;
    assign bus.ShiftEN   = shift_en_q;
    assign bus.CaptureEN = 1'b0;
    assign bus.UpdateEn  = update_en_q;
    assign bus.Select    = select_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Pass      = pass_q;
    assign bus.LockedOut = locked_q;
    assign bus.Tries     = tries_q;
endmodule

// File: tb/tb_mlsib_key_injector.sv
// tb/tb_mlsib_key_injector.sv - scoreboard bench for the lock-SIB key injector with a behavioural SIB
module tb_mlsib_key_injector;
    localparam int LEN    = 8;
    localparam int PAD    = 1;
    localparam int MAXT   = 3;
    localparam int SETTLE = 2;
    localparam logic [7:0] GOOD_KEY = 8'hA5;

    typedef struct {
        logic [7:0] key;
        logic       pass;
        int         tries;
        logic       locked;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   upd_cnt = 0;

    exp_t exp_q[$];
    logic si_bits[$];
    int   m_tries = 0;
    logic m_locked = 1'b0;

    logic [8:0] sib_sr = '0;
    logic       sib_open = 1'b0;
    logic       ovr_en = 1'b0;
    logic       ovr_val = 1'b0;

    mlsib_key_injector_if #(.Length(LEN), .TriesW(2)) bus();

    mlsib_key_injector #(
        .Length(LEN), .PadBits(PAD), .MaxTries(MAXT), .SettleCyc(SETTLE)
    ) dut (
        .Clock(clk),
        .Rst  (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lock SIB: chain SI -> sib bit -> key register; opens on update only with the right key.
    always @(posedge clk) begin
        if (bus.ShiftEN) sib_sr <= {bus.SI, sib_sr[8:1]};
        if (bus.UpdateEn) sib_open <= (sib_sr[7:0] == GOOD_KEY);
    end
    assign bus.SibOpen = ovr_en ? ovr_val : sib_open;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    exp_t       mon_e;
    logic [8:0] mon_got;
    always @(negedge clk) begin
        if (rst) begin
            si_bits.delete();
        end else begin
            chk("shift_and_update_exclusive", 32'(bus.ShiftEN & bus.UpdateEn), 0);
            chk("capture_en_low", 32'(bus.CaptureEN), 0);
            if (bus.ShiftEN) begin
                if (exp_q.size() == 0) chk("unexpected_shift", 1, 0);
                si_bits.push_back(bus.SI);
            end
            if (bus.UpdateEn) begin
                upd_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    chk("shift_len", si_bits.size(), LEN + PAD);
                    mon_got = '0;
                    for (int i = 0; i < si_bits.size() && i < 9; i++) mon_got[i] = si_bits[i];
                    chk("si_stream", 32'(mon_got), 32'({1'b1, exp_q[0].key}));
                end
                si_bits.delete();
            end
            if (bus.Done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pass", 32'(bus.Pass), 32'(mon_e.pass));
                    chk("tries", 32'(bus.Tries), mon_e.tries);
                    chk("locked_out", 32'(bus.LockedOut), 32'(mon_e.locked));
                    chk("done_latency", cyc, mon_e.done_cyc);
                    chk("busy_at_done", 32'(bus.Busy), 0);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] k);
        exp_t e;
        @(posedge clk); #1;
        bus.KeyIn   = k;
        bus.KeyLoad = 1'b1;
        if (!m_locked) begin
            e.key    = k;
            e.pass   = (k == GOOD_KEY);
            m_tries  = e.pass ? 0 : m_tries + 1;
            m_locked = (m_tries >= MAXT);
            e.tries  = m_tries;
            e.locked = m_locked;
            e.done_cyc = cyc + (1 + LEN + PAD + 1 + SETTLE);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.KeyLoad = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("attempt_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_tries  = 0;
        m_locked = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 32'({bus.SI, bus.ShiftEN, bus.UpdateEn, bus.Select, bus.Busy,
                                bus.Done, bus.Pass, bus.LockedOut, bus.Tries}), 0);
    endtask

    initial begin
        int u0;
        logic [7:0] k;
        bus.KeyIn   = '0;
        bus.KeyLoad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({bus.SI, bus.ShiftEN, bus.UpdateEn, bus.Select, bus.Busy,
                                  bus.Done, bus.Pass, bus.LockedOut, bus.Tries}), 0);

        issue(GOOD_KEY);
        wait_done();

        issue(GOOD_KEY);
        repeat (3) @(posedge clk);
        #1;
        bus.KeyIn = 8'hFF; bus.KeyLoad = 1'b1;
        @(posedge clk); #1;
        bus.KeyLoad = 1'b0;
        wait_done();

        issue(8'h00);
        wait_done();
        issue(8'h3C);
        wait_done();
        issue(GOOD_KEY);
        wait_done();
        chk("tries_after_good", 32'(bus.Tries), 0);

        // SibOpen wiggles during shift/update/settle but is low for the sampled cycles.
        issue(8'h00);
        ovr_en = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            ovr_val = (j % 2 == 1) ? 1'b1 : 1'(($urandom));
            @(posedge clk); #1;
        end
        ovr_val = 1'b0;
        wait_done();
        ovr_en = 1'b0;

        u0 = upd_cnt;
        issue(GOOD_KEY);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_tries = 0;
        @(negedge clk);
        chk("rst_mid_shift_shift_en", 32'(bus.ShiftEN), 0);
        chk("rst_mid_shift_busy", 32'(bus.Busy), 0);
        chk("rst_mid_shift_tries", 32'(bus.Tries), 0);
        chk("rst_mid_shift_no_update", upd_cnt, u0);
        chk("rst_mid_shift_sib_closed", 32'(sib_open), 0);
        issue(GOOD_KEY);
        wait_done();

        for (int i = 0; i < 3; i++) begin
            issue(8'h00);
            wait_done();
        end
        issue(GOOD_KEY);
        repeat (20) @(negedge clk);
        chk("lockout_sticky", 32'(bus.LockedOut), 1);
        chk("lockout_tries", 32'(bus.Tries), MAXT);
        chk("lockout_busy", 32'(bus.Busy), 0);
        do_reset();

        for (int i = 0; i < 30; i++) begin
            k = ($urandom_range(0, 2) == 0) ? GOOD_KEY : 8'($urandom);
            issue(k);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 8)) @(posedge clk);
                #1;
                bus.KeyIn = 8'($urandom); bus.KeyLoad = 1'b1;
                @(posedge clk); #1;
                bus.KeyLoad = 1'b0;
            end
            wait_done();
            if (m_locked) begin
                issue(GOOD_KEY);
                repeat (15) @(negedge clk);
                chk("rand_lockout", 32'(bus.LockedOut), 1);
                do_reset();
            end
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
